// File: rtl/inst_queue.sv
// inst_queue: instruction queue between fetch and decode.
//
// It buffers fetched RV32 instruction words and their PCs in a circular FIFO
// of DEPTH entries. The head entry goes to the decoder over a valid/ready
// handshake. A flush empties the queue in one cycle.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   CNT_W  width of the occupancy count
//
// Ports:
//   clk, rst        core clock; asynchronous active-high reset
//   i_fetch_vld     fetch offers an instruction
//   o_fetch_rdy     queue can accept (not full)
//   i_fetch_inst    instruction word from fetch
//   i_fetch_pc      PC of that word
//   o_dec_vld       head instruction valid toward decode
//   i_dec_rdy       decoder accepts the head instruction
//   o_dec_inst      head instruction word (zero when empty)
//   o_dec_pc        head PC (zero when empty)
//   i_flush         discard all entries
//   o_count         occupancy, 0..DEPTH
//   o_full, o_empty occupancy flags
//
// Optional feature: define IQ_BYPASS_EN to add a same-cycle fetch-to-decode
// path that is used when the queue is empty.

`ifndef RV32_INST_WIDTH
`define RV32_INST_WIDTH 32
`endif

module inst_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_fetch_vld,
  output logic                        o_fetch_rdy,
  input  logic [`RV32_INST_WIDTH-1:0] i_fetch_inst,
  input  logic [31:0]                 i_fetch_pc,
  output logic                        o_dec_vld,
  input  logic                        i_dec_rdy,
  output logic [`RV32_INST_WIDTH-1:0] o_dec_inst,
  output logic [31:0]                 o_dec_pc,
  input  logic                        i_flush,
  output logic [CNT_W-1:0]            o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Storage is not reset; only the pointers and the count are.
  logic [`RV32_INST_WIDTH-1:0] inst_q [DEPTH];
  logic [31:0]                 pc_q   [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty, full, bypass, enq, deq;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef IQ_BYPASS_EN
  // A word offered to an empty queue while decode is ready goes straight
  // through. Nothing is stored. The rst term keeps outputs at reset values.
  assign bypass = empty && i_fetch_vld && i_dec_rdy && !i_flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed transfer is not stored, so it counts as neither an enqueue
  // nor a dequeue of the storage.
  assign enq = i_fetch_vld && !full && !i_flush && !bypass;
  assign deq = !empty && i_dec_rdy && !i_flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[wr_ptr_q] <= i_fetch_inst;
      pc_q[wr_ptr_q]   <= i_fetch_pc;
    end
  end

  always_comb begin
    o_dec_inst = '0;
    o_dec_pc   = '0;
    if (bypass) begin
      o_dec_inst = i_fetch_inst;
      o_dec_pc   = i_fetch_pc;
    end else if (!empty) begin
      o_dec_inst = inst_q[rd_ptr_q];
      o_dec_pc   = pc_q[rd_ptr_q];
    end
  end

  assign o_fetch_rdy = !full;
  assign o_dec_vld   = (!empty || bypass) && !i_flush;
  assign o_count     = count_q;
  assign o_full      = full;
  assign o_empty     = empty;

endmodule

// File: tb/tb_inst_queue.sv
`ifndef RV32_INST_WIDTH
`define RV32_INST_WIDTH 32
`endif

module tb_inst_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IW    = `RV32_INST_WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_fetch_vld = 1'b0;
  logic             o_fetch_rdy;
  logic [IW-1:0]    i_fetch_inst = '0;
  logic [31:0]      i_fetch_pc = '0;
  logic             o_dec_vld;
  logic             i_dec_rdy = 1'b0;
  logic [IW-1:0]    o_dec_inst;
  logic [31:0]      o_dec_pc;
  logic             i_flush = 1'b0;
  logic [CNT_W-1:0] o_count;
  logic             o_full;
  logic             o_empty;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_vld  (i_fetch_vld),
    .o_fetch_rdy  (o_fetch_rdy),
    .i_fetch_inst (i_fetch_inst),
    .i_fetch_pc   (i_fetch_pc),
    .o_dec_vld    (o_dec_vld),
    .i_dec_rdy    (i_dec_rdy),
    .o_dec_inst   (o_dec_inst),
    .o_dec_pc     (o_dec_pc),
    .i_flush      (i_flush),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, inst} entries.
  logic [IW+31:0] mq[$];

  // Inputs change only just after posedge, so the values seen at negedge
  // are the ones the next posedge will act on.
  always @(negedge clk) begin
    logic        byp;
    logic        accept, take;
    logic [IW-1:0] e_inst;
    logic [31:0] e_pc;
    int          sz;
    if (rst) mq.delete();
    sz = mq.size();
`ifdef IQ_BYPASS_EN
    byp = (sz == 0) && i_fetch_vld && i_dec_rdy && !i_flush && !rst;
`else
    byp = 1'b0;
`endif
    e_inst = '0;
    e_pc   = '0;
    if (byp) begin
      e_inst = i_fetch_inst;
      e_pc   = i_fetch_pc;
    end else if (sz > 0) begin
      e_inst = mq[0][IW-1:0];
      e_pc   = mq[0][IW+31:IW];
    end
    check("m_count", 64'(o_count), 64'(sz));
    check("m_empty", 64'(o_empty), 64'(sz == 0));
    check("m_full", 64'(o_full), 64'(sz == DEPTH));
    check("m_fetch_rdy", 64'(o_fetch_rdy), 64'(sz < DEPTH));
    check("m_dec_vld", 64'(o_dec_vld), 64'(((sz > 0) || byp) && !i_flush));
    check("m_dec_inst", 64'(o_dec_inst), 64'(e_inst));
    check("m_dec_pc", 64'(o_dec_pc), 64'(e_pc));
    if (!rst) begin
      if (i_flush) begin
        mq.delete();
      end else begin
        accept = i_fetch_vld && (sz < DEPTH) && !byp;
        take   = (sz > 0) && i_dec_rdy;
        if (take) void'(mq.pop_front());
        if (accept) mq.push_back({i_fetch_pc, i_fetch_inst});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic vld, input logic [IW-1:0] inst, input logic [31:0] pc);
    i_fetch_vld  = vld;
    i_fetch_inst = inst;
    i_fetch_pc   = pc;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();
    #1;
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_full", 64'(o_full), 64'd0);
    check("rst_fetch_rdy", 64'(o_fetch_rdy), 64'd1);
    check("rst_dec_vld", 64'(o_dec_vld), 64'd0);
    check("rst_dec_inst", 64'(o_dec_inst), 64'd0);

    // Single enqueue, visible the next cycle.
    offer(1'b1, 32'h0000_0013, 32'h0000_1000);
    next_cycle();
    offer(1'b0, '0, '0);
    #1;
    check("one_vld", 64'(o_dec_vld), 64'd1);
    check("one_inst", 64'(o_dec_inst), 64'h0000_0013);
    check("one_pc", 64'(o_dec_pc), 64'h1000);
    check("one_count", 64'(o_count), 64'd1);
    i_dec_rdy = 1'b1;
    next_cycle();
    i_dec_rdy = 1'b0;

    // Fill to full with decode stalled.
    for (int i = 0; i < DEPTH; i++) begin
      offer(1'b1, 32'h1000_0000 + 32'(i), 32'h2000 + 32'(4 * i));
      next_cycle();
    end
    offer(1'b1, 32'hBAD0_0001, 32'hBAD0);
    #1;
    check("full_flag", 64'(o_full), 64'd1);
    check("full_rdy", 64'(o_fetch_rdy), 64'd0);
    next_cycle();
    offer(1'b0, '0, '0);
    #1;
    check("full_count_hold", 64'(o_count), 64'(DEPTH));
    i_dec_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_inst", 64'(o_dec_inst), 64'(32'h1000_0000 + 32'(i)));
      next_cycle();
      #1;
    end
    i_dec_rdy = 1'b0;
    check("drain_empty", 64'(o_empty), 64'd1);
    check("drain_inst_zero", 64'(o_dec_inst), 64'd0);

    // Sustained streaming across several pointer wraps.
    i_dec_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      offer(1'b1, 32'h3000_0000 + 32'(i), 32'h4000 + 32'(4 * i));
      next_cycle();
    end
    offer(1'b0, '0, '0);
    next_cycle();
    i_dec_rdy = 1'b0;
    #1;
    check("stream_empty", 64'(o_empty), 64'd1);

    // Flush with five queued; the same-cycle word must be dropped.
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 32'h5000_0000 + 32'(i), 32'h6000 + 32'(4 * i));
      next_cycle();
    end
    offer(1'b1, 32'hDEAD_BEEF, 32'hDEAD);
    i_dec_rdy = 1'b1;
    i_flush   = 1'b1;
    #1;
    check("flush_vld", 64'(o_dec_vld), 64'd0);
    next_cycle();
    offer(1'b0, '0, '0);
    i_dec_rdy = 1'b0;
    i_flush   = 1'b0;
    #1;
    check("flush_count", 64'(o_count), 64'd0);
    check("flush_empty", 64'(o_empty), 64'd1);
    offer(1'b1, 32'h0000_0777, 32'h7000);
    next_cycle();
    offer(1'b0, '0, '0);
    #1;
    check("post_flush_head", 64'(o_dec_inst), 64'h0000_0777);
    i_dec_rdy = 1'b1;
    next_cycle();
    i_dec_rdy = 1'b0;

    // Asynchronous reset between edges with three queued.
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h8000_0000 + 32'(i), 32'h9000 + 32'(4 * i));
      next_cycle();
    end
    offer(1'b0, '0, '0);
    #1;
    check("pre_rst_count", 64'(o_count), 64'd3);
    #1 rst = 1'b1;
    #1;
    check("arst_count", 64'(o_count), 64'd0);
    check("arst_vld", 64'(o_dec_vld), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();
    offer(1'b1, 32'h0000_0055, 32'hA000);
    next_cycle();
    offer(1'b0, '0, '0);
    #1;
    check("post_rst_head", 64'(o_dec_inst), 64'h0000_0055);
    check("post_rst_count", 64'(o_count), 64'd1);
    i_dec_rdy = 1'b1;
    next_cycle();

    // Empty queue with fetch and decode both ready.
    offer(1'b1, 32'h00A0_0093, 32'hB000);
    #1;
`ifdef IQ_BYPASS_EN
    check("byp_vld", 64'(o_dec_vld), 64'd1);
    check("byp_inst", 64'(o_dec_inst), 64'h00A0_0093);
    next_cycle();
    offer(1'b0, '0, '0);
    #1;
    check("byp_count", 64'(o_count), 64'd0);
    check("byp_vld_after", 64'(o_dec_vld), 64'd0);
`else
    check("nobyp_vld", 64'(o_dec_vld), 64'd0);
    next_cycle();
    offer(1'b0, '0, '0);
    #1;
    check("nobyp_vld_next", 64'(o_dec_vld), 64'd1);
    check("nobyp_inst_next", 64'(o_dec_inst), 64'h00A0_0093);
`endif
    next_cycle();
    i_dec_rdy = 1'b0;
    repeat (2) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
